// File: rtl/quadrant_divider.sv
// Angle range reduction for the sin/cos core: reduces an unsigned degree value modulo 360
// and folds it to a first-quadrant reference angle plus quadrant index, one registered stage.
module quadrant_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  en_divider,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [1:0]            quadrant,
    output logic [DATA_WIDTH-1:0] data_out
);

    // Restoring reduction: remove 360<<k whenever it fits, largest multiple first.
    // Before each step rem < 720<<k, so one conditional subtract per stage is exact.
    function automatic logic [8:0] mod_360(input logic [DATA_WIDTH-1:0] x);
        logic [DATA_WIDTH-1:0] rem;
        logic [DATA_WIDTH-1:0] step;
        rem = x;
        for (int k = DATA_WIDTH - 9; k >= 0; k--) begin
            step = DATA_WIDTH'(9'd360) << k;
            if (rem >= step) begin
                rem = rem - step;
            end else begin
                rem = rem;
            end
        end
        return rem[8:0];
    endfunction

    logic [8:0] angle_s;
    logic [1:0] quad_s;
    logic [8:0] ref_s;

    // Reduce the input and fold it into quadrant plus reference angle (0..90).
    always_comb begin
        angle_s = mod_360(data_in);
        quad_s  = 2'd0;
        ref_s   = 9'd0;
        if (angle_s < 9'd90) begin
            quad_s = 2'd0;
            ref_s  = angle_s;
        end else if (angle_s < 9'd180) begin
            quad_s = 2'd1;
            ref_s  = 9'd180 - angle_s;
        end else if (angle_s < 9'd270) begin
            quad_s = 2'd2;
            ref_s  = angle_s - 9'd180;
        end else begin
            quad_s = 2'd3;
            ref_s  = 9'd360 - angle_s;
        end
    end

    // Output register: cleared asynchronously, loaded on enable, otherwise held.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            quadrant <= 2'd0;
            data_out <= {DATA_WIDTH{1'b0}};
        end else if (en_divider) begin
            quadrant <= quad_s;
            data_out <= {{(DATA_WIDTH-9){1'b0}}, ref_s};
        end else begin
            quadrant <= quadrant;
            data_out <= data_out;
        end
    end

endmodule

// File: tb/tb_quadrant_divider.sv
// Self-checking bench for quadrant_divider: directed boundary cases, hold, async reset,
// and randomized inputs compared against an arithmetic reference model.
module tb_quadrant_divider;

    logic        clk;
    logic        reset_n;
    logic        en_divider;
    logic [31:0] data_in;
    logic [1:0]  quadrant;
    logic [31:0] data_out;

    int checks_cnt   = 0;
    int failures_cnt = 0;

    quadrant_divider #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en_divider (en_divider),
        .data_in    (data_in),
        .quadrant   (quadrant),
        .data_out   (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            failures_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: quadrant is a/90, reference angle is the distance to the nearest 0/180/360 axis.
    function automatic void ref_fold(input logic [31:0] x, output logic [31:0] q, output logic [31:0] d);
        longint unsigned a;
        a = longint'(x) % 360;
        q = 32'(a / 90);
        case (q)
            32'd0:   d = 32'(a);
            32'd1:   d = 32'(180 - a);
            32'd2:   d = 32'(a - 180);
            default: d = 32'(360 - a);
        endcase
    endfunction

    task automatic apply_exp(input logic [31:0] x, input logic [31:0] eq, input logic [31:0] ed, input string tag);
        @(negedge clk);
        data_in    = x;
        en_divider = 1'b1;
        @(posedge clk);
        #1;
        check_val({tag, "_q"}, {30'd0, quadrant}, eq);
        check_val({tag, "_d"}, data_out, ed);
    endtask

    task automatic apply_model(input logic [31:0] x, input string tag);
        logic [31:0] q;
        logic [31:0] d;
        ref_fold(x, q, d);
        apply_exp(x, q, d, tag);
    endtask

    logic [31:0] dir_x [14] = '{32'd45, 32'd135, 32'd200, 32'd300, 32'd0, 32'd90, 32'd180,
                                32'd270, 32'd359, 32'd360, 32'd400, 32'hFFFF_FFFF, 32'd1000000, 32'd720};
    logic [31:0] dir_q [14] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1, 32'd2,
                                32'd3, 32'd3, 32'd0, 32'd0, 32'd2, 32'd3, 32'd0};
    logic [31:0] dir_d [14] = '{32'd45, 32'd45, 32'd20, 32'd60, 32'd0, 32'd90, 32'd0,
                                32'd90, 32'd1, 32'd0, 32'd40, 32'd75, 32'd80, 32'd0};

    initial begin
        reset_n    = 1'b0;
        en_divider = 1'b0;
        data_in    = 32'd0;
        #3;
        check_val("reset_q", {30'd0, quadrant}, 32'd0);
        check_val("reset_d", data_out, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            apply_exp(dir_x[i], dir_q[i], dir_d[i], $sformatf("dir%0d", i));
        end

        // Hold with enable low
        apply_exp(32'd135, 32'd1, 32'd45, "hold_load");
        @(negedge clk);
        en_divider = 1'b0;
        data_in    = 32'd300;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_val($sformatf("hold%0d_q", i), {30'd0, quadrant}, 32'd1);
            check_val($sformatf("hold%0d_d", i), data_out, 32'd45);
        end

        // Asynchronous reset mid-cycle, then recovery
        apply_exp(32'd300, 32'd3, 32'd60, "pre_rst");
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("async_rst_q", {30'd0, quadrant}, 32'd0);
        check_val("async_rst_d", data_out, 32'd0);
        @(negedge clk);
        data_in    = 32'd45;
        en_divider = 1'b1;
        @(posedge clk);
        #1;
        check_val("rst_hold_q", {30'd0, quadrant}, 32'd0);
        check_val("rst_hold_d", data_out, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        apply_exp(32'd200, 32'd2, 32'd20, "post_rst");

        // Randomized ranges
        for (int i = 0; i < 20; i++) begin
            apply_model($urandom_range(32'hFFFF_FFFF, 32'd360), $sformatf("rnd_big%0d", i));
            apply_model($urandom_range(32'd359, 32'd181), $sformatf("rnd_q23_%0d", i));
            apply_model($urandom_range(32'd179, 32'd91), $sformatf("rnd_q1_%0d", i));
            apply_model($urandom_range(32'd89, 32'd0), $sformatf("rnd_q0_%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
        $finish;
    end

endmodule
